hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It generates the stall, flush and forwarding controls that the pipeline registers and execute-stage muxes consume; flushE drives the clr input of the ID/EX register. It handles load-use stalls, branch/jump flushes and a multi-cycle data-memory wait with a timeout FSM. It also keeps a saturating stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles for memReadyM before a forced release.
- CNT_W, 32: width of stallCycles.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  5  execute-stage source and destination registers.
- resultSrcE  in  2  execute-stage result source; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in execute.
- RdM, RdW  in  5  memory- and writeback-stage destinations.
- regWriteM, regWriteW  in  1  register-write enables for the M and W stages.
- memReqM  in  1  M-stage instruction is a load or store; held level.
- memReadyM  in  1  data memory completes the access this cycle.
- stallF, stallD, stallE, stallM  out  1  hold the corresponding pipeline register.
- flushD, flushE, flushW  out  1  clear the corresponding pipeline register.
- forwardAE, forwardBE  out  2  ALU operand select: 00 regfile, 01 from W, 10 from M.
- memErr  out  1  sticky flag set when a memory access times out.
- stallCycles  out  CNT_W  count of cycles with stallF high; saturates at all-ones.

## Operation
- Forwarding is combinational. For each of Rs1E and Rs2E:
  - 10 if regWriteM, RdM≠0 and RdM matches.
  - Otherwise 01 if regWriteW, RdW≠0 and RdW matches.
  - Otherwise 00. M has priority over W.
- lwStall = (resultSrcE==2'b01) & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- memStall = memReqM & ~memReadyM & (state≠RELEASE).
- Stage controls:
  - stallF = stallD = lwStall | memStall.
  - stallE = stallM = flushW = memStall.
  - flushD = PCSrcE & ~memStall.
  - flushE = (lwStall | PCSrcE) & ~memStall.
  - A frozen E stage is never cleared.
- FSM states are RUN, WAIT and RELEASE.
  - RUN: if memStall, go to WAIT and set waitCnt=1.
  - WAIT: if memReadyM, go to RUN. Else if waitCnt==MEM_TIMEOUT-1, go to RELEASE and set memErr. Else increment waitCnt.
  - RELEASE: lasts one cycle. memStall is forced low so the M instruction retires. Then go to RUN.
- memErr stays set until rst.
- stallCycles increments on every cycle with stallF=1 and holds at 2^CNT_W-1.

## Timing
- Reset values (sampled at posedge with rst=1):
  - state=RUN, waitCnt=0, memErr=0, stallCycles=0.
  - While rst is high, all stall and flush outputs are forced to 0 and forwardAE/forwardBE to 00.
- Latency:
  - Stall, flush and forward outputs respond in the same cycle as their inputs; there is no registered delay.
  - memErr rises one cycle after the timeout cycle.
- Simultaneous events:
  - Load-use and PCSrcE together: flushE=1, flushD=1, stallF=stallD=1.
  - memStall together with PCSrcE: flushD and flushE are suppressed until the wait ends. PCSrcE is re-evaluated then, because E is held.
- memReadyM arriving in the same cycle as memReqM gives no stall and no FSM transition.
- With the default MEM_TIMEOUT, a persistent not-ready access stalls for exactly MEM_TIMEOUT cycles, then one RELEASE cycle.
- Reset asserted mid-WAIT returns the FSM to RUN on the next edge and clears memErr.

## Structure
- riscv_pkg holds:
  - RESULT_LOAD = 2'b01.
  - FWD_REG = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - The hz_state_t enum {RUN, WAIT, RELEASE}.
- forward_unit is a natural sub-module: combinational, instantiated once per operand.
- The FSM, waitCnt, memErr and stallCycles stay in hazard_unit.

## Test plan
- Forward priority: Rs1E=5, RdM=5, RdW=5, regWriteM=1, regWriteW=1 -> forwardAE=10. Then regWriteM=0 -> 01. Then RdW=0 -> 00.
- Load-use: resultSrcE=01, RdE=3, Rs2D=3 -> stallF=stallD=flushE=1 for one cycle and stallCycles +1. The same case with RdE=0 -> no stall.
- Branch: PCSrcE=1, no load-use -> flushD=flushE=1 and stallF=0.
- Memory wait: memReqM=1 with memReadyM low for 3 cycles -> stallF/D/E/M=flushW=1 for 3 cycles and stallCycles=3. Then memReadyM=1 -> all stalls drop in the same cycle.
- Timeout: MEM_TIMEOUT=4, memReadyM never high -> 4 stall cycles, one RELEASE cycle with stalls low, memErr=1 and still set 10 cycles later.
- Reset mid-WAIT: rst pulsed in the second wait cycle -> the next cycle shows state RUN, memErr=0, stallCycles=0, and all outputs at 0 while rst is high.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the core's hazard logic: result-source codes,
// forwarding-mux selects and the memory-wait FSM state type.
package riscv_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT    = 2'b01,
        RELEASE = 2'b10
    } hz_state_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one execute-stage source register.
// The M stage holds the younger result, so it wins over W.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       we_m,
    input  logic       we_w,
    output logic [1:0] fwd
);

    // Pick the youngest in-flight writer of rs; x0 is never forwarded.
    always_comb begin
        fwd = FWD_REG;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end else begin
            fwd = FWD_REG;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the five-stage pipeline, including the
// data-memory wait FSM with timeout release and a saturating stall counter.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       resultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memReqM,
    input  logic             memReadyM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCycles
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_r;
    hz_state_t         state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_nxt_s;
    logic              timeout_s;
    logic              mem_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              lw_stall_s;
    logic              mem_stall_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    forward_unit u_fwd_a (
        .rs   (Rs1E),
        .rd_m (RdM),
        .rd_w (RdW),
        .we_m (regWriteM),
        .we_w (regWriteW),
        .fwd  (fwd_a_s)
    );

    forward_unit u_fwd_b (
        .rs   (Rs2E),
        .rd_m (RdM),
        .rd_w (RdW),
        .we_m (regWriteM),
        .we_w (regWriteW),
        .fwd  (fwd_b_s)
    );

    // Hazard detection; RELEASE masks the memory stall so the access retires.
    always_comb begin
        lw_stall_s  = (resultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
        mem_stall_s = memReqM && !memReadyM && (state_r != RELEASE);
    end

    // Stage controls; a frozen E stage is never cleared, and reset quiets all.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAE = FWD_REG;
        forwardBE = FWD_REG;
        if (rst) begin
            stallF = 1'b0;
        end else begin
            stallF    = lw_stall_s || mem_stall_s;
            stallD    = lw_stall_s || mem_stall_s;
            stallE    = mem_stall_s;
            stallM    = mem_stall_s;
            flushW    = mem_stall_s;
            flushD    = PCSrcE && !mem_stall_s;
            flushE    = (lw_stall_s || PCSrcE) && !mem_stall_s;
            forwardAE = fwd_a_s;
            forwardBE = fwd_b_s;
        end
    end

    // Memory-wait FSM next state; waitCnt counts stalled cycles of this access.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_nxt_s    = WAIT;
                    wait_cnt_nxt_s = WCNT_W'(1);
                end else begin
                    state_nxt_s = RUN;
                end
            end
            WAIT: begin
                if (memReadyM) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == WCNT_W'(MEM_TIMEOUT - 1)) begin
                    state_nxt_s = RELEASE;
                    timeout_s   = 1'b1;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WCNT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s    = RUN;
                wait_cnt_nxt_s = {WCNT_W{1'b0}};
            end
        endcase
    end

    // State, sticky timeout flag and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= {WCNT_W{1'b0}};
            mem_err_r   <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            mem_err_r  <= mem_err_r || timeout_s;
            if (stallF) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign memErr      = mem_err_r;
    assign stallCycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed table, multi-cycle corner sequences and
// random traffic, all checked against a behavioural model of the pipeline rules.
module tb_hazard_unit;

    localparam int T    = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    resultSrcE;
    logic          PCSrcE, regWriteM, regWriteW, memReqM, memReadyM;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]    forwardAE, forwardBE;
    logic          memErr;
    logic [CW-1:0] stallCycles;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int m_run;
    bit m_rel;
    bit m_err;
    int m_cnt;

    // values sampled at the last negedge
    logic [10:0]   cap_ctrl;
    logic          cap_err;
    logic [CW-1:0] cap_cnt;

    hazard_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .resultSrcE(resultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .memErr(memErr), .stallCycles(stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_in();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; resultSrcE = 2'd0; PCSrcE = 1'b0;
        regWriteM = 1'b0; regWriteW = 1'b0; memReqM = 1'b0; memReadyM = 1'b0;
    endtask

    // One clock cycle: compare at negedge against the model, then advance the model.
    task automatic do_cycle(input string tag);
        bit lw, ms, sf;
        logic [10:0] exp_ctrl;
        @(negedge clk);
        lw = (resultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        ms = memReqM && !memReadyM && !m_rel;
        sf = lw || ms;
        if (rst) exp_ctrl = 11'd0;
        else exp_ctrl = {sf, sf, ms, ms, PCSrcE && !ms, (lw || PCSrcE) && !ms, ms,
                         fwd_ref(Rs1E, RdM, RdW, regWriteM, regWriteW),
                         fwd_ref(Rs2E, RdM, RdW, regWriteM, regWriteW)};
        cap_ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, forwardAE, forwardBE};
        cap_err  = memErr;
        cap_cnt  = stallCycles;
        check({tag, " ctrl"}, 32'(cap_ctrl), 32'(exp_ctrl));
        check({tag, " memErr"}, 32'(cap_err), 32'(m_err));
        check({tag, " stallCycles"}, 32'(cap_cnt), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_rel = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (sf) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            if (m_rel) begin
                m_rel = 1'b0; m_run = 0;
            end else if (ms) begin
                m_run++;
                if (m_run == T) begin m_rel = 1'b1; m_err = 1'b1; m_run = 0; end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [4:0] rdm, rdw;
        logic       wm, ww;
        logic       stf, fld, fle;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs [11];
    int   base;

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd9, 5'd7, 5'd0, 2'd0, 1'b0, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[7]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[9]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 2'd1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[10] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 2'd2, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

        clear_in();
        rst = 1'b1;
        m_run = 0; m_rel = 1'b0; m_err = 1'b0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset forces outputs quiet even with hazards present
        Rs1E = 5'd5; RdM = 5'd5; regWriteM = 1'b1; memReqM = 1'b1; PCSrcE = 1'b1;
        do_cycle("reset");
        check("reset outputs zero", 32'(cap_ctrl), 32'd0);
        rst = 1'b0;
        clear_in();

        // directed table
        for (int i = 0; i < 11; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; resultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
            RdM = vecs[i].rdm; RdW = vecs[i].rdw; regWriteM = vecs[i].wm; regWriteW = vecs[i].ww;
            do_cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d stallF", i), 32'(cap_ctrl[10]), 32'(vecs[i].stf));
            check($sformatf("vec%0d flushD", i), 32'(cap_ctrl[6]), 32'(vecs[i].fld));
            check($sformatf("vec%0d flushE", i), 32'(cap_ctrl[5]), 32'(vecs[i].fle));
            check($sformatf("vec%0d fwdA", i), 32'(cap_ctrl[3:2]), 32'(vecs[i].fa));
            check($sformatf("vec%0d fwdB", i), 32'(cap_ctrl[1:0]), 32'(vecs[i].fb));
        end
        clear_in();

        // memory wait of 3 cycles, branch pending from the second cycle
        memReqM = 1'b1;
        base = 0;
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i > 0);
            do_cycle($sformatf("memwait%0d", i));
            if (i == 0) base = int'(cap_cnt);
            check($sformatf("memwait%0d stalls", i),
                  32'({cap_ctrl[10:7], cap_ctrl[4]}), 32'h1f);
            check($sformatf("memwait%0d flushes", i), 32'(cap_ctrl[6:5]), 32'd0);
        end
        memReadyM = 1'b1;
        do_cycle("memready");
        check("memready stalls", 32'({cap_ctrl[10:7], cap_ctrl[4]}), 32'd0);
        check("memready flushD", 32'(cap_ctrl[6]), 32'd1);
        check("memready count delta", 32'(int'(cap_cnt) - base), 32'd3);
        clear_in();
        do_cycle("idle");

        // timeout: T stall cycles, one release cycle, sticky memErr
        memReqM = 1'b1;
        for (int i = 0; i <= T; i++) begin
            do_cycle($sformatf("timeout%0d", i));
            check($sformatf("timeout%0d stallF", i), 32'(cap_ctrl[10]), 32'(i < T));
            check($sformatf("timeout%0d memErr", i), 32'(cap_err), 32'(i == T));
        end
        clear_in();
        repeat (10) do_cycle("after timeout");
        check("memErr sticky", 32'(cap_err), 32'd1);

        // reset during the second wait cycle
        memReqM = 1'b1;
        do_cycle("rstwait run");
        do_cycle("rstwait wait1");
        rst = 1'b1;
        do_cycle("rstwait rst");
        check("rstwait outputs zero", 32'(cap_ctrl), 32'd0);
        rst = 1'b0;
        memReqM = 1'b0;
        do_cycle("rstwait after");
        check("rstwait memErr", 32'(cap_err), 32'd0);
        check("rstwait stallCycles", 32'(cap_cnt), 32'd0);
        check("rstwait no stall", 32'(cap_ctrl[10]), 32'd0);

        // counter saturation under a persistent load-use stall
        resultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        repeat (260) do_cycle("saturate");
        check("stallCycles saturated", 32'(cap_cnt), 32'(CMAX));
        clear_in();

        // random traffic against the model; memReqM held while a wait is open
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            resultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            memReqM   = (m_run > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            memReadyM = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            do_cycle($sformatf("rand%0d", i));
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
